// File: rtl/rvv_backend_vrf_rdport.sv
// ============================================================================
// Module   : rvv_backend_vrf_rdport
// Brief    : Register-group read port. Streams 1..8 consecutive vector
//            registers as beats through a single valid/ready output register.
//            Optional macro VRF_RD_BYPASS_EN forwards same-cycle writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef NUM_VRF
`define NUM_VRF 32
`endif
`ifndef VLEN
`define VLEN 128
`endif

module rvv_backend_vrf_rdport (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [`NUM_VRF-1:0][`VLEN-1:0]  vreg,
    input  logic [`NUM_VRF-1:0][`VLEN-1:0]  wenb,
    input  logic [`NUM_VRF-1:0][`VLEN-1:0]  wdata,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    input  logic [4:0]                      rd_addr,
    input  logic [1:0]                      rd_emul,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [`VLEN-1:0]                rsp_data,
    output logic [2:0]                      rsp_idx,
    output logic                            rsp_last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_base;
    logic [2:0]         r_nm1;
    logic [2:0]         r_cnt;
    logic               r_rsp_valid;
    logic [`VLEN-1:0]   r_rsp_data;
    logic [2:0]         r_rsp_idx;
    logic               r_rsp_last;

    logic               w_slot_free;
    logic               w_accept;
    logic               w_busy_cap;
    logic               w_cap;
    logic [2:0]         w_req_nm1;
    logic [2:0]         w_idx;
    logic               w_last;
    logic [4:0]         w_sel;
    logic [`VLEN-1:0]   w_beat;

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign rd_ready    = (r_state == IDLE) && w_slot_free;
    assign w_accept    = rd_valid && rd_ready;
    assign w_busy_cap  = (r_state == BUSY) && w_slot_free;
    assign w_cap       = w_accept || w_busy_cap;

    always_comb begin
        w_req_nm1 = 3'd0;
        case (rd_emul)
            2'd0:    w_req_nm1 = 3'd0;
            2'd1:    w_req_nm1 = 3'd1;
            2'd2:    w_req_nm1 = 3'd3;
            default: w_req_nm1 = 3'd7;
        endcase
    end

    // Beat 0 comes straight from the request; later beats from latched state.
    assign w_idx  = w_accept ? 3'd0 : r_cnt;
    assign w_last = w_accept ? (rd_emul == 2'd0) : (r_cnt == r_nm1);
    assign w_sel  = (w_accept ? rd_addr : r_base) + {2'b00, w_idx};

`ifdef VRF_RD_BYPASS_EN
    assign w_beat = (wenb[w_sel] & wdata[w_sel]) | (~wenb[w_sel] & vreg[w_sel]);
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{wenb, wdata};
    assign w_beat      = vreg[w_sel];
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && (rd_emul != 2'd0)) w_state_nxt = BUSY;
            BUSY:    if (w_busy_cap && w_last)          w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= 5'd0;
            r_nm1       <= 3'd0;
            r_cnt       <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_idx   <= 3'd0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base <= rd_addr;
                r_nm1  <= w_req_nm1;
                r_cnt  <= (rd_emul == 2'd0) ? 3'd0 : 3'd1;
            end else if (w_busy_cap) begin
                r_cnt  <= w_last ? 3'd0 : r_cnt + 3'd1;
            end

            // Output register only loads when the slot is free, so a stalled
            // beat is frozen regardless of later register-file activity.
            if (w_cap) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_beat;
                r_rsp_idx   <= w_idx;
                r_rsp_last  <= w_last;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_idx   = r_rsp_idx;
    assign rsp_last  = r_rsp_last;

endmodule

`default_nettype wire
